regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised general-purpose register file for the multicycle core.
//  Two registered read ports (A/B operands), one write-back port.
//  Write-to-read bypass, optional hardwired zero register, per-register
//  pending scoreboard raising a hazard flag toward the control FSM.
//  Sits between decode (rs/rt/rd) and the ALU operand latches.
// PARAMETERS
//  DATA_W    32  width of each register and data port
//  DEPTH     32  number of registers (need not be a power of two)
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never pending
//  ADDR_W    (localparam) $clog2(DEPTH), minimum 1
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       asynchronous reset, active low
//  rs          in   ADDR_W  read address, port A
//  rt          in   ADDR_W  read address, port B
//  rd_en_a     in   1       capture port A this cycle
//  rd_en_b     in   1       capture port B this cycle
//  rd          in   ADDR_W  write-back address
//  wr_en       in   1       write i_data to rd this cycle
//  i_data      in   DATA_W  write-back data
//  issue_en    in   1       instruction issued that will write issue_rd
//  issue_rd    in   ADDR_W  destination being marked pending
//  out_data_a  out  DATA_W  registered operand A
//  out_data_b  out  DATA_W  registered operand B
//  hazard      out  1       rs or rt pending and not resolved this cycle
// BEHAVIOUR
//  Reset (rst_n low, async): all DEPTH registers = 0, out_data_a/b = 0,
//   pending[] = 0, so hazard = 0. Held while rst_n low; no writes,
//   reads or issues take effect until the first edge after release.
//  "Writable": wr_en=1, rd < DEPTH, and not (ZERO_REG=1 and rd=0).
//  Write: if writable at edge, mem[rd] <= i_data. Otherwise no change.
//  Read A (latency 1): at edge with rd_en_a=1, out_data_a <=
//   - 0 if rs >= DEPTH, or ZERO_REG=1 and rs=0;
//   - else i_data if writable and rd==rs (bypass, new value wins);
//   - else mem[rs].
//   rd_en_a=0: out_data_a holds. Port B identical with rt/rd_en_b.
//  Both ports may read the same address in one cycle; both get the
//   same (bypassed) value.
//  Scoreboard, per register r, at each edge:
//   set   = issue_en && issue_rd==r
//   clear = wr_en && rd==r
//   set wins over clear (the new producer is still outstanding).
//   ZERO_REG=1: pending[0] stays 0. Addresses >= DEPTH ignored.
//  hazard (combinational from pending and current inputs):
//   (pending[rs] && !(writable && rd==rs)) ||
//   (pending[rt] && !(writable && rd==rt)).
//   Out-of-range rs/rt contribute 0. Same-cycle write-back clears the
//   hazard because the bypass supplies the value.
//  Write to a non-pending register is legal; it updates mem and leaves
//   pending at 0.
//  No internal FSM beyond storage and scoreboard; the caller must hold
//   rd_en_a/b low while hazard=1, or accept stale data.
// TESTING
//  1 Reset: rst_n=0 mid-run after writes -> out_data_a/b=0, hazard=0,
//    every register reads 0 after release.
//  2 Write then read: wr rd=5 d=32'hDEADBEEF; next cycle rs=5 rd_en_a=1
//    -> out_data_a=32'hDEADBEEF one edge later; rd_en_a=0 holds it.
//  3 Bypass: same edge wr rd=7 d=32'h12345678, rs=rt=7, rd_en_a/b=1
//    -> both outputs 32'h12345678 (old value 0 not seen).
//  4 Zero reg: ZERO_REG=1, wr rd=0 d=32'hFFFFFFFF, issue_rd=0 -> reading
//    r0 gives 0, hazard stays 0. ZERO_REG=0 build: r0 reads FFFFFFFF.
//  5 Scoreboard: issue_rd=3; next cycle rs=3 -> hazard=1; wr rd=3 on a
//    later edge -> hazard=0 in that cycle, pending[3]=0 after. Issue
//    and write rd=3 on same edge -> pending[3] stays 1.
//  6 DEPTH=24: wr rd=30 ignored, rs=30 reads 0, no hazard, no X.

Source files
------------

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two registered read ports and one
// write-back port. It sits between decode and the ALU operand latches.
// A same-cycle write is forwarded to the read ports, register 0 can be
// hardwired to zero, and a per-register pending scoreboard drives a
// hazard flag toward the control FSM.
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              hazard
);

  // DEPTH need not be a power of two, so addresses are range-checked
  // with one extra bit of headroom.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              writable;
  logic [DATA_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_b;
  logic              pend_a;
  logic              pend_b;
  logic [DATA_W-1:0] next_a;
  logic [DATA_W-1:0] next_b;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_EXT);
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // A write only lands on a real register that is not the hardwired zero.
  always_comb begin
    writable = wr_en && in_range(rd) && !is_zero(rd);
  end

  // Look up stored data and pending bits. The search loop never indexes
  // past DEPTH, so out-of-range addresses simply find nothing.
  always_comb begin
    mem_a  = '0;
    mem_b  = '0;
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (rs == ADDR_W'(r)) begin
        mem_a  = mem[r];
        pend_a = pending[r];
      end
      if (rt == ADDR_W'(r)) begin
        mem_b  = mem[r];
        pend_b = pending[r];
      end
    end
  end

  // Select the operand values: zero for r0 or out of range, then the
  // bypassed write-back data, then the stored value.
  always_comb begin
    if (!in_range(rs) || is_zero(rs)) begin
      next_a = '0;
    end else if (writable && (rd == rs)) begin
      next_a = i_data;
    end else begin
      next_a = mem_a;
    end
    if (!in_range(rt) || is_zero(rt)) begin
      next_b = '0;
    end else if (writable && (rd == rt)) begin
      next_b = i_data;
    end else begin
      next_b = mem_b;
    end
  end

  // Raise a hazard when an operand is still outstanding, unless this
  // cycle's write-back resolves it through the bypass.
  always_comb begin
    hazard = (pend_a && !(writable && (rd == rs))) ||
             (pend_b && !(writable && (rd == rt)));
  end

  // Register storage: clear on reset, otherwise take the write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (writable && (rd == ADDR_W'(r))) begin
          mem[r] <= i_data;
        end
      end
    end
  end

  // Operand output registers; each one holds while its read enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_a <= '0;
      out_data_b <= '0;
    end else begin
      if (rd_en_a) begin
        out_data_a <= next_a;
      end
      if (rd_en_b) begin
        out_data_b <= next_b;
      end
    end
  end

  // Scoreboard. A new issue wins over a write-back to the same register,
  // because that newer producer is still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if ((ZERO_REG != 0) && (r == 0)) begin
          pending[r] <= 1'b0;
        end else if (issue_en && (issue_rd == ADDR_W'(r))) begin
          pending[r] <= 1'b1;
        end else if (wr_en && (rd == ADDR_W'(r))) begin
          pending[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: drives two register-file builds with the same inputs.
// dut_main uses DEPTH=32 with a hardwired zero register. dut_alt uses
// DEPTH=24 with a writable register 0. A directed table is checked
// against hand-derived values, and every cycle both builds are also
// checked against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs, rt, rd, issue_rd;
  logic        rd_en_a, rd_en_b, wr_en, issue_en;
  logic [31:0] i_data;
  logic [31:0] a_main, b_main, a_alt, b_alt;
  logic        h_main, h_alt;

  int checks   = 0;
  int failures = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(32), .DEPTH(32), .ZERO_REG(1)) dut_main (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd_en_a(rd_en_a),
    .rd_en_b(rd_en_b), .rd(rd), .wr_en(wr_en), .i_data(i_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .out_data_a(a_main),
    .out_data_b(b_main), .hazard(h_main)
  );

  regfile_2r1w #(.DATA_W(32), .DEPTH(24), .ZERO_REG(0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd_en_a(rd_en_a),
    .rd_en_b(rd_en_b), .rd(rd), .wr_en(wr_en), .i_data(i_data),
    .issue_en(issue_en), .issue_rd(issue_rd), .out_data_a(a_alt),
    .out_data_b(b_alt), .hazard(h_alt)
  );

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        ea;
    logic        eb;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        ie;
    logic [4:0]  ird;
    logic        exp_h;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  // Reference model: index 0 mirrors dut_main, index 1 mirrors dut_alt.
  int          cfg_depth [2] = '{32, 24};
  int          cfg_zero  [2] = '{1, 0};
  logic [31:0] m_mem  [2][32];
  bit          m_pend [2][32];
  logic [31:0] m_a [2];
  logic [31:0] m_b [2];

  function automatic bit m_writable(int c);
    return wr_en && (int'(rd) < cfg_depth[c]) && !(cfg_zero[c] != 0 && rd == 0);
  endfunction

  function automatic logic [31:0] m_read(int c, int addr);
    if (addr >= cfg_depth[c] || (cfg_zero[c] != 0 && addr == 0)) return 32'h0;
    if (m_writable(c) && int'(rd) == addr) return i_data;
    return m_mem[c][addr];
  endfunction

  function automatic bit m_pending(int c, int addr);
    return (addr < cfg_depth[c]) && m_pend[c][addr];
  endfunction

  function automatic logic m_hazard(int c);
    return (m_pending(c, int'(rs)) && !(m_writable(c) && rd == rs)) ||
           (m_pending(c, int'(rt)) && !(m_writable(c) && rd == rt));
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_a[c] = 32'h0;
      m_b[c] = 32'h0;
      for (int r = 0; r < 32; r++) begin
        m_mem[c][r]  = 32'h0;
        m_pend[c][r] = 1'b0;
      end
    end
  endtask

  task automatic m_clock();
    for (int c = 0; c < 2; c++) begin
      if (rd_en_a) m_a[c] = m_read(c, int'(rs));
      if (rd_en_b) m_b[c] = m_read(c, int'(rt));
      if (m_writable(c)) m_mem[c][rd] = i_data;
      if (wr_en && int'(rd) < cfg_depth[c]) m_pend[c][rd] = 1'b0;
      if (issue_en && int'(issue_rd) < cfg_depth[c] &&
          !(cfg_zero[c] != 0 && issue_rd == 0))
        m_pend[c][issue_rd] = 1'b1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rs = v.rs; rt = v.rt; rd_en_a = v.ea; rd_en_b = v.eb;
    rd = v.rd; wr_en = v.we; i_data = v.data;
    issue_en = v.ie; issue_rd = v.ird;
  endtask

  // One cycle, entered and left at a falling edge: drive the inputs, check
  // the hazard, clock the model with the DUTs, then check the operands.
  task automatic runCycle(input vec_t v, input bit use_table, input string tag);
    applyStimulus(v);
    #1;
    checkOutput({tag, "_haz_main"}, {31'b0, h_main}, {31'b0, m_hazard(0)});
    checkOutput({tag, "_haz_alt"},  {31'b0, h_alt},  {31'b0, m_hazard(1)});
    if (use_table) checkOutput({tag, "_tbl_haz"}, {31'b0, h_main}, {31'b0, v.exp_h});
    m_clock();
    @(posedge clk);
    #1;
    checkOutput({tag, "_a_main"}, a_main, m_a[0]);
    checkOutput({tag, "_b_main"}, b_main, m_b[0]);
    checkOutput({tag, "_a_alt"},  a_alt,  m_a[1]);
    checkOutput({tag, "_b_alt"},  b_alt,  m_b[1]);
    if (use_table) begin
      checkOutput({tag, "_tbl_a"}, a_main, v.exp_a);
      checkOutput({tag, "_tbl_b"}, b_main, v.exp_b);
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(int rs_, int rt_, int ea, int eb, int rd_, int we,
                              logic [31:0] d, int ie, int ird, int eh,
                              logic [31:0] xa, logic [31:0] xb);
    vec_t v;
    v.rs = 5'(rs_); v.rt = 5'(rt_); v.ea = 1'(ea); v.eb = 1'(eb);
    v.rd = 5'(rd_); v.we = 1'(we); v.data = d; v.ie = 1'(ie);
    v.ird = 5'(ird); v.exp_h = 1'(eh); v.exp_a = xa; v.exp_b = xb;
    return v;
  endfunction

  vec_t tbl [15];
  vec_t v;

  initial begin
    // Directed table, with expectations worked out by hand for dut_main.
    // Fields: rs rt ea eb rd we data ie ird | hazard a b
    tbl[0]  = mk(0, 0, 0, 0, 5, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0, 32'h0);
    tbl[1]  = mk(5, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'hDEADBEEF, 32'h0);
    tbl[3]  = mk(7, 7, 1, 1, 7, 1, 32'h12345678, 0, 0, 0, 32'h12345678, 32'h12345678);
    tbl[4]  = mk(0, 0, 1, 1, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h0, 32'h0);
    tbl[5]  = mk(0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0, 1, 3, 0, 32'h0, 32'h0);
    tbl[7]  = mk(3, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0);
    tbl[8]  = mk(3, 0, 1, 0, 3, 1, 32'h33, 0, 0, 0, 32'h33, 32'h0);
    tbl[9]  = mk(3, 3, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h33, 32'h0);
    tbl[10] = mk(0, 0, 0, 0, 3, 1, 32'h44, 1, 3, 0, 32'h33, 32'h0);
    tbl[11] = mk(0, 3, 0, 1, 0, 0, 32'h0, 0, 0, 1, 32'h33, 32'h44);
    tbl[12] = mk(0, 3, 0, 1, 3, 1, 32'h55, 0, 0, 0, 32'h33, 32'h55);
    tbl[13] = mk(30, 5, 1, 1, 30, 1, 32'hAAAA0000, 0, 0, 0, 32'hAAAA0000, 32'hDEADBEEF);
    tbl[14] = mk(30, 7, 1, 1, 0, 0, 32'h0, 0, 0, 0, 32'hAAAA0000, 32'h12345678);

    // Power-on reset with every input idle.
    rst_n = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
    m_reset();
    repeat (2) @(negedge clk);
    checkOutput("rst_a_main", a_main, 32'h0);
    checkOutput("rst_b_main", b_main, 32'h0);
    checkOutput("rst_haz_main", {31'b0, h_main}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) runCycle(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Leave register 4 pending and register 9 written, then pull reset
    // asynchronously while the inputs point at them.
    runCycle(mk(0, 0, 0, 0, 9, 1, 32'h99, 1, 4, 0, 0, 0), 1'b0, "pre_rst");
    applyStimulus(mk(4, 9, 1, 1, 9, 1, 32'h77, 1, 6, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checkOutput("midrst_a_main", a_main, 32'h0);
    checkOutput("midrst_b_alt", b_alt, 32'h0);
    checkOutput("midrst_haz_main", {31'b0, h_main}, 32'h0);
    checkOutput("midrst_haz_alt", {31'b0, h_alt}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_a", a_main, 32'h0);
    checkOutput("midrst_hold_b", b_main, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      runCycle(mk(r, 31 - r, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0), 1'b0, "postrst");
      checkOutput($sformatf("postrst_r%0d", r), a_main, 32'h0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 31), ($urandom_range(0, 2) != 0) ? 1 : 0,
             $urandom, ($urandom_range(0, 2) == 0) ? 1 : 0,
             $urandom_range(0, 31), 0, 32'h0, 32'h0);
      runCycle(v, 1'b0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
